// File: rtl/alu_fun_issue_arb.sv
// Round-robin arbiter for the four ALU operation-class request lines.
// The winner is encoded into a registered 2-bit ALU_FUN code and handed
// downstream with a valid/ready handshake. An optional number of idle
// cycles can be forced after every accepted transfer.
module alu_fun_issue_arb #(
    parameter int GAP_CYCLES = 0,
    parameter int GAP_W      = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Req_Arith,
    input  logic       Req_Logic,
    input  logic       Req_CMP,
    input  logic       Req_Shift,
    input  logic       ALU_Ready,
    output logic [1:0] ALU_FUN,
    output logic       ALU_Valid,
    output logic [3:0] Grant,
    output logic [3:0] Ack,
    output logic       Busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    // Counter preload: the transfer edge itself is not counted, so the
    // counter runs GAP_CYCLES-1 .. 0 and the last GAP edge re-arbitrates.
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t           state_q;
    logic [1:0]       fun_q;
    logic             valid_q;
    logic [3:0]       grant_q;
    logic [1:0]       ptr_q;
    logic [GAP_W-1:0] cnt_q;

    logic [3:0]       req_d;
    logic [1:0]       start_d;
    logic [2:0]       pick_d;
    logic             pick_hit_d;
    logic [1:0]       pick_idx_d;
    logic [3:0]       pick_grant_d;
    logic             xfer_d;

    // Scan from 'start' upward with wrap; the first asserted line wins.
    // Returns {found, index}.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign req_d  = {Req_Shift, Req_CMP, Req_Logic, Req_Arith};
    assign xfer_d = valid_q & ALU_Ready;

    // The code equals the requester index, so on a transfer the updated
    // pointer is simply the current code plus one; searching from it lets
    // back-to-back issue use the new priority in the same edge.
    assign start_d      = (state_q == S_ISSUE) ? (fun_q + 2'd1) : ptr_q;
    assign pick_d       = rr_pick(req_d, start_d);
    assign pick_hit_d   = pick_d[2];
    assign pick_idx_d   = pick_d[1:0];
    assign pick_grant_d = 4'b0001 << pick_idx_d;

    // Issue FSM with registered function code, valid, grant and pointer.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            fun_q   <= 2'b00;
            valid_q <= 1'b0;
            grant_q <= 4'b0000;
            ptr_q   <= 2'b00;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pick_hit_d) begin
                        fun_q   <= pick_idx_d;
                        grant_q <= pick_grant_d;
                        valid_q <= 1'b1;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (xfer_d) begin
                        ptr_q <= fun_q + 2'd1;
                        if (GAP_CYCLES == 0) begin
                            if (pick_hit_d) begin
                                fun_q   <= pick_idx_d;
                                grant_q <= pick_grant_d;
                            end else begin
                                valid_q <= 1'b0;
                                grant_q <= 4'b0000;
                                state_q <= S_IDLE;
                            end
                        end else begin
                            valid_q <= 1'b0;
                            grant_q <= 4'b0000;
                            cnt_q   <= GAP_LOAD;
                            state_q <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (cnt_q == '0) begin
                        if (pick_hit_d) begin
                            fun_q   <= pick_idx_d;
                            grant_q <= pick_grant_d;
                            valid_q <= 1'b1;
                            state_q <= S_ISSUE;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    grant_q <= 4'b0000;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ALU_FUN   = fun_q;
    assign ALU_Valid = valid_q;
    assign Grant     = grant_q;
    assign Ack       = grant_q & {4{xfer_d}};
    assign Busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_fun_issue_arb.sv
// Bench for alu_fun_issue_arb: two instances (no gap, gap of 3) share the
// stimulus; a behavioural model tracks each one.
module tb_alu_fun_issue_arb;

    localparam int GW = 4;
    localparam int G3 = 3;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       rdy = 1'b0;

    logic [1:0] fun0, fun3;
    logic       v0, v3, b0, b3;
    logic [3:0] g0, g3, a0, a3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    alu_fun_issue_arb #(.GAP_CYCLES(0), .GAP_W(GW)) u_dut0 (
        .CLK(CLK), .RST(RST),
        .Req_Arith(req[0]), .Req_Logic(req[1]), .Req_CMP(req[2]), .Req_Shift(req[3]),
        .ALU_Ready(rdy), .ALU_FUN(fun0), .ALU_Valid(v0), .Grant(g0), .Ack(a0), .Busy(b0)
    );

    alu_fun_issue_arb #(.GAP_CYCLES(G3), .GAP_W(GW)) u_dut3 (
        .CLK(CLK), .RST(RST),
        .Req_Arith(req[0]), .Req_Logic(req[1]), .Req_CMP(req[2]), .Req_Shift(req[3]),
        .ALU_Ready(rdy), .ALU_FUN(fun3), .ALU_Valid(v3), .Grant(g3), .Ack(a3), .Busy(b3)
    );

    initial begin
        assert (G3 <= (1 << GW) - 1)
        else $fatal(1, "gap parameter does not fit the counter");
    end

    // Model: v = an op is pending, own = its owner, fun = last code shown,
    // ptr = round-robin start, gap = forced idle cycles still to run.
    typedef struct packed {
        logic       v;
        logic [1:0] own;
        logic [1:0] fun;
        logic [1:0] ptr;
        logic [4:0] gap;
    } mst_t;

    mst_t m0, m3;

    function automatic mst_t arb(input mst_t s, input logic [3:0] r);
        mst_t n;
        int   i;
        n = s;
        for (int k = 0; k < 4; k++) begin
            i = (int'(s.ptr) + k) % 4;
            if (r[i] && !n.v) begin
                n.v   = 1'b1;
                n.own = 2'(i);
                n.fun = 2'(i);
            end
        end
        return n;
    endfunction

    function automatic mst_t step(input mst_t s, input int g, input logic [3:0] r, input logic rd);
        mst_t n;
        n = s;
        if (s.gap != 0) begin
            n.gap = s.gap - 5'd1;
            if (n.gap == 0) n = arb(n, r);
        end else if (!s.v) begin
            n = arb(n, r);
        end else if (rd) begin
            n.ptr = s.own + 2'd1;
            n.v   = 1'b0;
            if (g > 0) n.gap = 5'(g);
            else       n = arb(n, r);
        end
        return n;
    endfunction

    // Expected {valid, fun, grant, busy, ack}.
    function automatic logic [11:0] expv(input mst_t s, input logic rd);
        logic [3:0] g;
        g = s.v ? (4'b0001 << s.own) : 4'b0000;
        return {s.v, s.fun, g, (s.v || (s.gap != 0)), (s.v && rd) ? g : 4'b0000};
    endfunction

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m0 <= '0;
            m3 <= '0;
        end else begin
            m0 <= step(m0, 0, req, rdy);
            m3 <= step(m3, G3, req, rdy);
        end
    end

    logic [11:0] obs0, obs3;
    assign obs0 = {v0, fun0, g0, b0, a0};
    assign obs3 = {v3, fun3, g3, b3, a3};

    task automatic test_reset;
        RST = 1'b1; req = 4'b0000; rdy = 1'b0;
        repeat (2) @(negedge CLK);
        n_cmp++; if (obs0 !== 12'h000) begin n_err++; $display("FAIL reset_dut0: got %b want %b", obs0, 12'h000); end
        n_cmp++; if (obs3 !== 12'h000) begin n_err++; $display("FAIL reset_dut3: got %b want %b", obs3, 12'h000); end
        RST = 1'b0;
    endtask

    task automatic test_single;
        req = 4'b0100; rdy = 1'b1;
        @(negedge CLK);
        n_cmp++; if (obs0 !== {1'b1, 2'b10, 4'b0100, 1'b1, 4'b0100}) begin n_err++; $display("FAIL single_issue: got %b want %b", obs0, {1'b1, 2'b10, 4'b0100, 1'b1, 4'b0100}); end
        n_cmp++; if (obs0 !== expv(m0, rdy)) begin n_err++; $display("FAIL single_model: got %b want %b", obs0, expv(m0, rdy)); end
        req = 4'b0000;
        @(negedge CLK);
        n_cmp++; if ({v0, g0, a0} !== 9'b0) begin n_err++; $display("FAIL single_drop: got %b want %b", {v0, g0, a0}, 9'b0); end
        n_cmp++; if (obs0 !== expv(m0, rdy)) begin n_err++; $display("FAIL single_drop_model: got %b want %b", obs0, expv(m0, rdy)); end
    endtask

    task automatic test_backpressure;
        req = 4'b1000; rdy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            n_cmp++; if ({v0, fun0, g0, a0} !== {1'b1, 2'b11, 4'b1000, 4'b0000}) begin n_err++; $display("FAIL bp_hold c%0d: got %b want %b", c, {v0, fun0, g0, a0}, {1'b1, 2'b11, 4'b1000, 4'b0000}); end
            if (c == 1) req = 4'b0000;
        end
        rdy = 1'b1;
        #1;
        n_cmp++; if (a0 !== 4'b1000) begin n_err++; $display("FAIL bp_ack: got %b want %b", a0, 4'b1000); end
        @(negedge CLK);
        n_cmp++; if ({v0, a0} !== 5'b0) begin n_err++; $display("FAIL bp_after: got %b want %b", {v0, a0}, 5'b0); end
        n_cmp++; if (obs0 !== expv(m0, rdy)) begin n_err++; $display("FAIL bp_model: got %b want %b", obs0, expv(m0, rdy)); end
    endtask

    task automatic test_pointer_wrap;
        req = 4'b0011; rdy = 1'b1;
        @(negedge CLK);
        n_cmp++; if ({v0, fun0, g0} !== {1'b1, 2'b00, 4'b0001}) begin n_err++; $display("FAIL wrap_first: got %b want %b", {v0, fun0, g0}, {1'b1, 2'b00, 4'b0001}); end
        req = 4'b0010;
        @(negedge CLK);
        n_cmp++; if ({v0, fun0, g0} !== {1'b1, 2'b01, 4'b0010}) begin n_err++; $display("FAIL wrap_second: got %b want %b", {v0, fun0, g0}, {1'b1, 2'b01, 4'b0010}); end
        req = 4'b0000;
        @(negedge CLK);
        n_cmp++; if (obs0 !== expv(m0, rdy)) begin n_err++; $display("FAIL wrap_model: got %b want %b", obs0, expv(m0, rdy)); end
    endtask

    task automatic test_round_robin;
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0; req = 4'b1111; rdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            n_cmp++; if ({v0, fun0} !== {1'b1, 2'(k % 4)}) begin n_err++; $display("FAIL rr_seq k%0d: got %b want %b", k, {v0, fun0}, {1'b1, 2'(k % 4)}); end
            n_cmp++; if (obs0 !== expv(m0, rdy)) begin n_err++; $display("FAIL rr_model k%0d: got %b want %b", k, obs0, expv(m0, rdy)); end
        end
        req = 4'b0000;
        @(negedge CLK);
    endtask

    task automatic test_gap;
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0; req = 4'b0011; rdy = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(negedge CLK);
            n_cmp++; if ({v3, b3, fun3} !== {(c % 4 == 0), 1'b1, 2'((c / 4) % 2)}) begin n_err++; $display("FAIL gap_seq c%0d: got %b want %b", c, {v3, b3, fun3}, {(c % 4 == 0), 1'b1, 2'((c / 4) % 2)}); end
            n_cmp++; if (obs3 !== expv(m3, rdy)) begin n_err++; $display("FAIL gap_model c%0d: got %b want %b", c, obs3, expv(m3, rdy)); end
        end
        req = 4'b0000;
        repeat (5) @(negedge CLK);
        n_cmp++; if ({v3, b3} !== 2'b00) begin n_err++; $display("FAIL gap_drain: got %b want %b", {v3, b3}, 2'b00); end
    endtask

    task automatic test_async_reset;
        req = 4'b0100; rdy = 1'b0;
        @(negedge CLK);
        n_cmp++; if ({v0, fun0} !== 3'b110) begin n_err++; $display("FAIL ar_pre: got %b want %b", {v0, fun0}, 3'b110); end
        @(posedge CLK);
        #2 RST = 1'b1;
        #1;
        n_cmp++; if (obs0 !== 12'h000) begin n_err++; $display("FAIL ar_mid_dut0: got %b want %b", obs0, 12'h000); end
        n_cmp++; if (obs3 !== 12'h000) begin n_err++; $display("FAIL ar_mid_dut3: got %b want %b", obs3, 12'h000); end
        @(negedge CLK);
        RST = 1'b0; req = 4'b0010; rdy = 1'b1;
        @(negedge CLK);
        n_cmp++; if ({v0, fun0, g0} !== {1'b1, 2'b01, 4'b0010}) begin n_err++; $display("FAIL ar_after: got %b want %b", {v0, fun0, g0}, {1'b1, 2'b01, 4'b0010}); end
        n_cmp++; if (obs0 !== expv(m0, rdy)) begin n_err++; $display("FAIL ar_model: got %b want %b", obs0, expv(m0, rdy)); end
        req = 4'b0000;
        repeat (5) @(negedge CLK);
    endtask

    task automatic test_random;
        for (int c = 0; c < 400; c++) begin
            @(negedge CLK);
            n_cmp++; if (obs0 !== expv(m0, rdy)) begin n_err++; $display("FAIL rand_dut0 c%0d: got %b want %b", c, obs0, expv(m0, rdy)); end
            n_cmp++; if (obs3 !== expv(m3, rdy)) begin n_err++; $display("FAIL rand_dut3 c%0d: got %b want %b", c, obs3, expv(m3, rdy)); end
            req = 4'($urandom);
            rdy = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_pointer_wrap();
        test_round_robin();
        test_gap();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
